vc_output_allocator: RTL and testbench
======================================

Name: vc_output_allocator

Overview:
- Per-output-port switch allocator in the router, directly downstream of the virtual_channel instances.
- Collects the per-output request bit from each of IN_N virtual channels and grants exactly one of them with round-robin priority.
- Holds the grant for the whole packet, head to tail, so wormhole ordering is preserved.
- Multiplexes the granted channel's flit stream onto the output link and returns the downstream buffer's readiness to the granted channel only.

Parameters:
- IN_N, 5, number of competing virtual channels (input ports); must be ≥2.
- FLIT_DATA_W, 8, flit payload width.
- FLIT_ID_W, 2, flit type field width.
- FLIT_W, FLIT_DATA_W+FLIT_ID_W, full flit width.
- IDX_W, $clog2(IN_N), width of the winner index.

Ports:
- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  IN_N  per-VC request for this output, taken from that VC's oc_req_o bit.
- data_i  input  IN_N*FLIT_W  per-VC flit; VC k occupies bits [k*FLIT_W +: FLIT_W].
- data_vld_i  input  IN_N  per-VC flit valid.
- is_tail_i  input  IN_N  per-VC flag: the presented flit is a tail.
- granted_o  output  IN_N  one-hot grant, driven to each VC's oc_granted_i.
- vc_rdy_o  output  IN_N  per-VC ready, driven to each VC's oc_rdy_i; equals rdy_i & granted_o[k].
- data_o  output  FLIT_W  flit forwarded to the downstream buffer.
- data_vld_o  output  1  forwarded flit valid.
- rdy_i  input  1  downstream buffer not full.
- busy_o  output  1  a grant is held (state GRANT).

Behaviour:
- State machine with two states, IDLE and GRANT. Reset puts the block in IDLE with:
  - granted_o=0, prio_ptr=0, winner=0;
  - busy_o=0, data_vld_o=0, data_o=0.
- IDLE:
  - If req_i≠0, pick the first set bit scanning prio_ptr, prio_ptr+1, … with wrap modulo IN_N.
  - Register that bit as winner and one-hot granted_o, then go to GRANT.
  - If req_i=0, stay in IDLE with outputs at reset values.
- GRANT:
  - data_o = data_i slice of winner; data_vld_o = data_vld_i[winner]; both combinational from the registered winner.
  - data_o is forced to 0 when data_vld_o=0.
  - A transfer occurs when data_vld_o & rdy_i.
  - A transfer with is_tail_i[winner]=1 causes, at that edge:
    - state → IDLE;
    - granted_o → 0;
    - prio_ptr → (winner+1) mod IN_N, with explicit wrap when winner=IN_N-1.
  - Non-tail transfers and stall cycles (vld=0 or rdy_i=0) keep the grant unchanged.
  - Changes on req_i are ignored while in GRANT; a deasserted req_i does not release the grant, only a tail does.
- Latency and timing:
  - Request to grant: 1 cycle (request seen in IDLE, grant visible the next cycle).
  - Flit path: 0 cycles, combinational mux.
  - Tail accepted at cycle t → IDLE at t+1 → next grant at t+2. One bubble cycle between packets is the decided cost.
- Single-flit packet (head flag and tail flag on the same flit): granted, transferred, released exactly as above.
- Backpressure:
  - rdy_i=0 holds the flit at the VC, because vc_rdy_o[winner]=0.
  - No flit is lost or duplicated.
  - vc_rdy_o is 0 for every non-granted VC regardless of rdy_i.
- Losing VCs keep requesting; no starvation. A VC that has just released its grant has lowest priority in the next arbitration.
- Reset asserted mid-packet: grant dropped at that edge, prio_ptr=0, and the partial packet is not completed by this block. The router resets the VCs together with this block.
- Invariants:
  - popcount(granted_o)≤1 at all times.
  - busy_o == (granted_o≠0).

Optional Feature:
- Macro: VC_OUTPUT_ALLOC_PKT_CNT_EN.
- When defined:
  - adds output pkt_cnt_o [15:0], the number of tail flits transferred since reset;
  - increments by 1 on every tail transfer;
  - saturates at 16'hFFFF;
  - resets to 0.
- When undefined, the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req_i=0 for 5 cycles → granted_o=0, data_vld_o=0, busy_o=0 throughout.
- req_i=5'b00100; VC2 sends a 3-flit packet (0x1A1, 0x0B2, tail 0x2C3) with rdy_i=1 → granted_o=5'b00100 one cycle after request; data_o carries the three flits on consecutive cycles; granted_o=0 the cycle after the tail; prio_ptr=3.
- req_i=5'b11111 held, every VC sends 1-flit packets → grant order 0,1,2,3,4,0, one bubble cycle between grants.
- VC1 granted, rdy_i=0 for 4 cycles mid-packet → vc_rdy_o=0, data_o holds the same flit, grant held; after rdy_i=1 the remaining flits follow in order with no duplicates.
- VC3 granted, VC3 drops req_i before its tail while VC0 requests → grant stays on VC3 until the tail transfers; VC0 is granted 2 cycles after the tail.
- Reset during the second flit of a 4-flit packet → next cycle granted_o=0, busy_o=0; a new request from VC4 is granted starting from prio_ptr=0. With VC_OUTPUT_ALLOC_PKT_CNT_EN, pkt_cnt_o=0 after reset and =2 after two tails.

Source files
------------

// File: rtl/vc_output_allocator.sv
`default_nettype none
// ============================================================================
// vc_output_allocator
//   Round-robin switch allocator for one output port; holds the grant from
//   head to tail and muxes the winning VC's flits onto the output link.
//   Optional macro VC_OUTPUT_ALLOC_PKT_CNT_EN adds pkt_cnt_o (tail count).
// Revision: 1.0
// ============================================================================
module vc_output_allocator #(
  parameter int IN_N        = 5,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int FLIT_W      = FLIT_DATA_W + FLIT_ID_W,
  parameter int IDX_W       = $clog2(IN_N)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IN_N-1:0]        req_i,
  input  logic [IN_N*FLIT_W-1:0] data_i,
  input  logic [IN_N-1:0]        data_vld_i,
  input  logic [IN_N-1:0]        is_tail_i,
  output logic [IN_N-1:0]        granted_o,
  output logic [IN_N-1:0]        vc_rdy_o,
  output logic [FLIT_W-1:0]      data_o,
  output logic                   data_vld_o,
  input  logic                   rdy_i,
  output logic                   busy_o
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
  ,
  output logic [15:0]            pkt_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [IN_N-1:0]   granted, granted_nxt;
  logic [IDX_W-1:0]  winner, winner_nxt;
  logic [IDX_W-1:0]  prio_ptr, prio_ptr_nxt;
  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  logic [FLIT_W-1:0] sel_data;
  logic              sel_vld;
  logic              sel_tail;
  logic              xfer;
  logic              tail_xfer;

  // First requester at or after prio_ptr, wrapping modulo IN_N.
  always_comb begin : arbitrate
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < IN_N; i++) begin
      idx = int'(prio_ptr) + i;
      if (idx >= IN_N) idx = idx - IN_N;
      if (!pick_vld && req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  // The one-hot grant register doubles as the mux select; all-zero in IDLE.
  always_comb begin : flit_mux
    sel_data = '0;
    sel_vld  = 1'b0;
    sel_tail = 1'b0;
    for (int k = 0; k < IN_N; k++) begin
      if (granted[k]) begin
        sel_data = data_i[k*FLIT_W +: FLIT_W];
        sel_vld  = data_vld_i[k];
        sel_tail = is_tail_i[k];
      end
    end
  end

  assign xfer      = sel_vld & rdy_i;
  assign tail_xfer = xfer & sel_tail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      granted  <= '0;
      winner   <= '0;
      prio_ptr <= '0;
    end else begin
      state    <= state_nxt;
      granted  <= granted_nxt;
      winner   <= winner_nxt;
      prio_ptr <= prio_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    granted_nxt  = granted;
    winner_nxt   = winner;
    prio_ptr_nxt = prio_ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt   = GRANT;
          winner_nxt  = pick;
          granted_nxt = IN_N'(1) << pick;
        end
      end
      GRANT: begin
        // Only a transferred tail releases; req_i is ignored here.
        if (tail_xfer) begin
          state_nxt    = IDLE;
          granted_nxt  = '0;
          prio_ptr_nxt = (winner == IDX_W'(IN_N - 1)) ? '0 : winner + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        granted_nxt = '0;
      end
    endcase
  end

  assign granted_o  = granted;
  assign vc_rdy_o   = granted & {IN_N{rdy_i}};
  assign data_vld_o = sel_vld;
  assign data_o     = sel_vld ? sel_data : '0;
  assign busy_o     = (state == GRANT);

`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
  logic [15:0] pkt_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt <= '0;
    end else if (tail_xfer && (pkt_cnt != 16'hFFFF)) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_output_allocator.sv
`default_nettype none
// Bench for vc_output_allocator: behavioural VCs feed the DUT and a
// scoreboard of expected (vc, flit, tail) entries checks the output stream.
module tb_vc_output_allocator;

  localparam int IN_N = 5;
  localparam int FW   = 10;
  localparam int MAXF = 8;

  typedef struct {
    int          vc;
    logic [FW-1:0] flit;
    logic        tl;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_N-1:0]   req = '0;
  logic [IN_N*FW-1:0] data = '0;
  logic [IN_N-1:0]   vld = '0;
  logic [IN_N-1:0]   tail = '0;
  logic [IN_N-1:0]   granted;
  logic [IN_N-1:0]   vc_rdy;
  logic [FW-1:0]     dout;
  logic              dvld;
  logic              rdy = 1'b1;
  logic              busy;
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
  logic [15:0]       pkt_cnt;
`endif

  logic [FW-1:0]     vflit [IN_N][MAXF];
  logic              vtail [IN_N][MAXF];
  int                vlen  [IN_N];
  int                vpos  [IN_N];
  logic [IN_N-1:0]   req_mask = '0;
  exp_t              exp_q[$];

  int                n_cmp = 0;
  int                n_bad = 0;
  int                tails_seen = 0;
  logic              tail_t1 = 1'b0;
  logic              tail_t2 = 1'b0;
  logic [IN_N-1:0]   req_prev = '0;

  always #5 clk = ~clk;

  vc_output_allocator #(
    .IN_N        (IN_N),
    .FLIT_DATA_W (8),
    .FLIT_ID_W   (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .data_i     (data),
    .data_vld_i (vld),
    .is_tail_i  (tail),
    .granted_o  (granted),
    .vc_rdy_o   (vc_rdy),
    .data_o     (dout),
    .data_vld_o (dvld),
    .rdy_i      (rdy),
    .busy_o     (busy)
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
    ,
    .pkt_cnt_o  (pkt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < IN_N; k++) begin
      if (vpos[k] < vlen[k]) begin
        vld[k]             = 1'b1;
        tail[k]            = vtail[k][vpos[k]];
        data[k*FW +: FW]   = vflit[k][vpos[k]];
      end else begin
        vld[k]             = 1'b0;
        tail[k]            = 1'b0;
        data[k*FW +: FW]   = '0;
      end
      req[k] = vld[k] & ~req_mask[k];
    end
  endtask

  // Queue a flit at VC k and push its expectation; call in expected output order.
  task automatic add_flit(input int k, input logic [FW-1:0] f, input logic tl);
    exp_t e;
    vflit[k][vlen[k]] = f;
    vtail[k][vlen[k]] = tl;
    vlen[k]++;
    e.vc = k; e.flit = f; e.tl = tl;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    check("onehot", 32'($countones(granted) <= 1), 32'(1));
    check("busy_eq_gnt", 32'(busy), 32'(granted != '0));
    check("vc_rdy", 32'(vc_rdy), 32'(granted & {IN_N{rdy}}));
    if (!dvld) check("dout_zero", 32'(dout), 32'(0));
    if (tail_t1) check("bubble_busy", 32'(busy), 32'(0));
    if (tail_t2 && req_prev != '0) check("regrant", 32'(granted != '0), 32'(1));
    tail_t2  = tail_t1;
    tail_t1  = 1'b0;
    req_prev = req;
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
    check("pkt_cnt", 32'(pkt_cnt), 32'(tails_seen));
`endif
    if (dvld) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q[0];
        check("flit_data", 32'(dout), 32'(e.flit));
        check("flit_vc", 32'(granted), 32'(1 << e.vc));
        if (rdy) begin
          void'(exp_q.pop_front());
          tail_t1 = e.tl;
          if (e.tl) tails_seen++;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [IN_N-1:0] pops;
    @(negedge clk);
    monitor();
    pops = vc_rdy & vld;
    @(posedge clk);
    #1;
    for (int k = 0; k < IN_N; k++) if (pops[k]) vpos[k]++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < IN_N; k++) begin
      vlen[k] = 0;
      vpos[k] = 0;
    end
    exp_q.delete();
    req_mask   = '0;
    tail_t1    = 1'b0;
    tail_t2    = 1'b0;
    req_prev   = '0;
    tails_seen = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      cycle();
      n++;
    end
    check("drain_in_time", 32'(n < maxc), 32'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rdy = 1'b1;
    do_reset();

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_gnt", 32'(granted), 32'(0));
      check("idle_vld", 32'(dvld), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end

    // 3-flit packet on VC2
    add_flit(2, 10'h1A1, 1'b0);
    add_flit(2, 10'h0B2, 1'b0);
    add_flit(2, 10'h2C3, 1'b1);
    drive();
    cycle();
    check("req2gnt", 32'(granted), 32'h04);
    for (int i = 0; i < 3; i++) cycle();
    check("vc2_back_to_back", 32'(exp_q.size()), 32'(0));
    cycle();
    check("vc2_release", 32'(granted), 32'(0));

    // prio_ptr=3 so VC4 beats VC1; VC1 then stalls for 4 cycles mid-packet
    add_flit(4, 10'h3D4, 1'b1);
    add_flit(1, 10'h011, 1'b0);
    add_flit(1, 10'h012, 1'b0);
    add_flit(1, 10'h213, 1'b1);
    drive();
    n = 0;
    while (!(granted[1] && vpos[1] == 1) && n < 20) begin cycle(); n++; end
    check("vc1_started", 32'(vpos[1]), 32'(1));
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_gnt", 32'(granted), 32'h02);
      check("stall_hold", 32'(dout), 32'h012);
    end
    rdy = 1'b1;
    drain(20);

    // All VCs request, 1-flit packets: order 0,1,2,3,4,0
    do_reset();
    add_flit(0, 10'h3A0, 1'b1);
    add_flit(1, 10'h3A1, 1'b1);
    add_flit(2, 10'h3A2, 1'b1);
    add_flit(3, 10'h3A3, 1'b1);
    add_flit(4, 10'h3A4, 1'b1);
    add_flit(0, 10'h3B0, 1'b1);
    drive();
    drain(40);

    // VC3 drops its request mid-packet while VC0 waits
    add_flit(3, 10'h153, 1'b0);
    drive();
    n = 0;
    while (granted != 5'b01000 && n < 10) begin cycle(); n++; end
    check("vc3_grant", 32'(granted), 32'h08);
    add_flit(3, 10'h054, 1'b0);
    add_flit(3, 10'h255, 1'b1);
    add_flit(0, 10'h3C0, 1'b1);
    req_mask[3] = 1'b1;
    drive();
    drain(20);
    req_mask = '0;

    // Reset mid-packet, then priority restarts at 0
    add_flit(2, 10'h142, 1'b0);
    add_flit(2, 10'h043, 1'b0);
    add_flit(2, 10'h044, 1'b0);
    add_flit(2, 10'h245, 1'b1);
    drive();
    n = 0;
    while (!(granted[2] && vpos[2] == 1) && n < 10) begin cycle(); n++; end
    check("vc2_midpkt", 32'(granted), 32'h04);
    do_reset();
    check("rst_gnt", 32'(granted), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
`endif
    add_flit(0, 10'h3F0, 1'b1);
    add_flit(4, 10'h3F4, 1'b1);
    drive();
    drain(20);
    cycle();
`ifdef VC_OUTPUT_ALLOC_PKT_CNT_EN
    check("pkt_cnt_two", 32'(pkt_cnt), 32'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
